// File: rtl/clock_pkg.sv
// Shared definitions for the digital clock stages (hours, minutes, seconds).
package clock_pkg;

    localparam int HOURS_PER_DAY = 24;
    localparam int HOUR_W        = 5;

    typedef logic [3:0] bcd_digit_t;

    // Two-digit BCD split of a binary value in 0..59; {tens, units}.
    function automatic logic [7:0] bin_to_bcd2(input logic [5:0] value);
        bcd_digit_t tens;
        logic [5:0] rem;
        if (value >= 6'd50) begin
            tens = 4'd5;
            rem  = value - 6'd50;
        end else if (value >= 6'd40) begin
            tens = 4'd4;
            rem  = value - 6'd40;
        end else if (value >= 6'd30) begin
            tens = 4'd3;
            rem  = value - 6'd30;
        end else if (value >= 6'd20) begin
            tens = 4'd2;
            rem  = value - 6'd20;
        end else if (value >= 6'd10) begin
            tens = 4'd1;
            rem  = value - 6'd10;
        end else begin
            tens = 4'd0;
            rem  = value;
        end
        return {tens, rem[3:0]};
    endfunction

endpackage

// File: rtl/hour_display_decode.sv
// Combinational 12/24-hour BCD view of the binary hour register.
module hour_display_decode
    import clock_pkg::*;
(
    input  logic [HOUR_W-1:0] hour,
    input  logic              mode_24h,
    output logic [1:0]        disp_tens,
    output logic [3:0]        disp_units,
    output logic              pm
);

    logic [HOUR_W-1:0] shown;
    logic [7:0]        bcd;

    // Pick the displayed value: 24h passes through, 12h maps 0->12 and 13..23->1..11.
    always_comb begin
        shown = hour;
        if (!mode_24h) begin
            if (hour == '0) begin
                shown = 5'd12;
            end else if (hour > 5'd12) begin
                shown = hour - 5'd12;
            end
        end
        bcd        = bin_to_bcd2({1'b0, shown});
        disp_tens  = bcd[5:4];
        disp_units = bcd[3:0];
        pm         = (hour >= 5'd12);
    end

endmodule

// File: rtl/hour_counter.sv
// Hour stage: advances on minute-rollover edges, validated direct load,
// day-rollover pulse and 12/24-hour BCD display.
module hour_counter
    import clock_pkg::*;
#(
    parameter int unsigned RESET_HOUR = 0
) (
    input  logic              clk_1Hz,
    input  logic              rst,
    input  logic              min_tick,
    input  logic              mode_24h,
    input  logic              load,
    input  logic [HOUR_W-1:0] load_hour,
    output logic [HOUR_W-1:0] hour,
    output logic [1:0]        disp_tens,
    output logic [3:0]        disp_units,
    output logic              pm,
    output logic              day_tick,
    output logic              load_err
);

    localparam logic [HOUR_W-1:0] RESET_HOUR_L = RESET_HOUR[HOUR_W-1:0];
    localparam logic [HOUR_W-1:0] LAST_HOUR    = HOUR_W'(HOURS_PER_DAY - 1);
    localparam logic [HOUR_W-1:0] HOUR_LIMIT   = HOUR_W'(HOURS_PER_DAY);

    logic [HOUR_W-1:0] hour_q, hour_d;
    logic              tick_d_q, tick_d_d;
    logic              day_tick_q, day_tick_d;
    logic              load_err_q, load_err_d;
    logic              adv;
    logic              load_ok;

    // Next-state: load (valid or not) beats advance; the tick history always
    // updates, so an edge coinciding with a load is consumed.
    always_comb begin
        tick_d_d   = min_tick;
        hour_d     = hour_q;
        day_tick_d = 1'b0;
        load_err_d = 1'b0;
        adv        = min_tick & ~tick_d_q & ~load;
        load_ok    = (load_hour < HOUR_LIMIT);
        if (load) begin
            if (load_ok) begin
                hour_d = load_hour;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (adv) begin
            if (hour_q == LAST_HOUR) begin
                hour_d     = '0;
                day_tick_d = 1'b1;
            end else begin
                hour_d = hour_q + 5'd1;
            end
        end
    end

    // State registers; tick history resets high so a level held through reset is ignored.
    always_ff @(posedge clk_1Hz) begin
        if (rst) begin
            hour_q     <= RESET_HOUR_L;
            tick_d_q   <= 1'b1;
            day_tick_q <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            hour_q     <= hour_d;
            tick_d_q   <= tick_d_d;
            day_tick_q <= day_tick_d;
            load_err_q <= load_err_d;
        end
    end

    assign hour     = hour_q;
    assign day_tick = day_tick_q;
    assign load_err = load_err_q;

    hour_display_decode u_decode (
        .hour       (hour_q),
        .mode_24h   (mode_24h),
        .disp_tens  (disp_tens),
        .disp_units (disp_units),
        .pm         (pm)
    );

endmodule

// File: tb/tb_hour_counter.sv
// Directed vector bench for hour_counter.
module tb_hour_counter;
    import clock_pkg::*;

    logic       clk_1Hz;
    logic       rst;
    logic       min_tick;
    logic       mode_24h;
    logic       load;
    logic [4:0] load_hour;
    logic [4:0] hour;
    logic [1:0] disp_tens;
    logic [3:0] disp_units;
    logic       pm;
    logic       day_tick;
    logic       load_err;

    int n_checks = 0;
    int n_fail   = 0;

    hour_counter #(.RESET_HOUR(0)) dut (
        .clk_1Hz    (clk_1Hz),
        .rst        (rst),
        .min_tick   (min_tick),
        .mode_24h   (mode_24h),
        .load       (load),
        .load_hour  (load_hour),
        .hour       (hour),
        .disp_tens  (disp_tens),
        .disp_units (disp_units),
        .pm         (pm),
        .day_tick   (day_tick),
        .load_err   (load_err)
    );

    initial clk_1Hz = 1'b0;
    always #5 clk_1Hz = ~clk_1Hz;

    typedef struct {
        logic       rst;
        logic       mt;
        logic       m24;
        logic       ld;
        logic [4:0] lh;
        logic [4:0] e_hour;
        logic [1:0] e_tens;
        logic [3:0] e_units;
        logic       e_pm;
        logic       e_day;
        logic       e_err;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input int idx, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic mt, input logic m24, input logic ld,
                       input int lh, input int eh, input int et, input int eu,
                       input logic epm, input logic eday, input logic eerr);
        vec_t v;
        v.rst = r; v.mt = mt; v.m24 = m24; v.ld = ld; v.lh = 5'(lh);
        v.e_hour = 5'(eh); v.e_tens = 2'(et); v.e_units = 4'(eu);
        v.e_pm = epm; v.e_day = eday; v.e_err = eerr;
        vq.push_back(v);
    endtask

    task automatic step(input logic mt, input logic ld, input int lh);
        @(negedge clk_1Hz);
        min_tick  = mt;
        load      = ld;
        load_hour = 5'(lh);
        @(posedge clk_1Hz);
        #1;
    endtask

    initial begin
        int advances;
        int day_seen;
        logic [4:0] prev_hour;

        rst = 1'b1; min_tick = 1'b1; mode_24h = 1'b1; load = 1'b0; load_hour = '0;

        //  rst mt m24 ld lh  hour tens units pm day err
        add(1, 1, 1, 0,  0,   0, 0, 0, 0, 0, 0);
        add(1, 1, 1, 0,  0,   0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) add(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0,  0,   0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0,  0,   1, 0, 1, 0, 0, 0);
        add(0, 1, 0, 0,  0,   1, 0, 1, 0, 0, 0);
        add(0, 1, 1, 1, 22,  22, 2, 2, 1, 0, 0);
        add(0, 0, 1, 0,  0,  22, 2, 2, 1, 0, 0);
        add(0, 1, 1, 0,  0,  23, 2, 3, 1, 0, 0);
        add(0, 0, 1, 0,  0,  23, 2, 3, 1, 0, 0);
        add(0, 1, 1, 0,  0,   0, 0, 0, 0, 1, 0);
        add(0, 1, 0, 0,  0,   0, 1, 2, 0, 0, 0);
        add(0, 1, 0, 1, 13,  13, 0, 1, 1, 0, 0);
        add(0, 1, 1, 0,  0,  13, 1, 3, 1, 0, 0);
        add(0, 1, 0, 1, 12,  12, 1, 2, 1, 0, 0);
        add(0, 1, 1, 1,  7,   7, 0, 7, 0, 0, 0);
        add(0, 1, 1, 1, 24,   7, 0, 7, 0, 0, 1);
        add(0, 1, 1, 0,  0,   7, 0, 7, 0, 0, 0);
        add(0, 1, 1, 1, 31,   7, 0, 7, 0, 0, 1);
        add(0, 1, 1, 0,  0,   7, 0, 7, 0, 0, 0);
        add(0, 0, 1, 1,  5,   5, 0, 5, 0, 0, 0);
        add(0, 1, 1, 1, 10,  10, 1, 0, 0, 0, 0);
        add(0, 1, 1, 0,  0,  10, 1, 0, 0, 0, 0);
        add(0, 0, 1, 0,  0,  10, 1, 0, 0, 0, 0);
        add(0, 1, 1, 0,  0,  11, 1, 1, 0, 0, 0);
        add(0, 1, 1, 1,  3,   3, 0, 3, 0, 0, 0);
        add(0, 1, 1, 1,  4,   4, 0, 4, 0, 0, 0);
        add(0, 0, 1, 0,  0,   4, 0, 4, 0, 0, 0);
        add(0, 1, 1, 0,  0,   5, 0, 5, 0, 0, 0);
        add(0, 0, 1, 0,  0,   5, 0, 5, 0, 0, 0);
        add(0, 1, 1, 0,  0,   6, 0, 6, 0, 0, 0);
        add(0, 1, 1, 1, 23,  23, 2, 3, 1, 0, 0);
        add(0, 1, 1, 1,  0,   0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 1,  9,   9, 0, 9, 0, 0, 0);
        add(0, 0, 1, 0,  0,   9, 0, 9, 0, 0, 0);
        add(1, 1, 1, 1,  5,   0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0,  0,   0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0,  0,   0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0,  0,   1, 0, 1, 0, 0, 0);
        add(0, 1, 0, 1, 23,  23, 1, 1, 1, 0, 0);
        add(0, 1, 0, 1, 11,  11, 1, 1, 0, 0, 0);

        foreach (vq[i]) begin
            @(negedge clk_1Hz);
            rst       = vq[i].rst;
            min_tick  = vq[i].mt;
            mode_24h  = vq[i].m24;
            load      = vq[i].ld;
            load_hour = vq[i].lh;
            @(posedge clk_1Hz);
            #1;
            check("hour",       i, int'(hour),       int'(vq[i].e_hour));
            check("disp_tens",  i, int'(disp_tens),  int'(vq[i].e_tens));
            check("disp_units", i, int'(disp_units), int'(vq[i].e_units));
            check("pm",         i, int'(pm),         int'(vq[i].e_pm));
            check("day_tick",   i, int'(day_tick),   int'(vq[i].e_day));
            check("load_err",   i, int'(load_err),   int'(vq[i].e_err));
        end

        // Long level: 60 high / 60 low, three times, from hour 0 -> exactly 3 advances.
        mode_24h = 1'b1;
        step(1'b0, 1'b1, 0);
        check("long_start", 0, int'(hour), 0);
        advances = 0;
        day_seen = 0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 120; c++) begin
                prev_hour = hour;
                step((c < 60) ? 1'b1 : 1'b0, 1'b0, 0);
                if (hour != prev_hour) advances++;
                if (day_tick) day_seen++;
            end
            check("long_hour", r, int'(hour), r + 1);
        end
        check("long_advances", 0, advances, 3);
        check("long_day_tick", 0, day_seen, 0);

        // Mode toggle between edges changes the display at once but never the hour.
        step(1'b0, 1'b1, 15);
        mode_24h = 1'b0;
        #1;
        check("mode12_hour",  0, int'(hour),       15);
        check("mode12_tens",  0, int'(disp_tens),  0);
        check("mode12_units", 0, int'(disp_units), 3);
        mode_24h = 1'b1;
        #1;
        check("mode24_tens",  0, int'(disp_tens),  1);
        check("mode24_units", 0, int'(disp_units), 5);
        step(1'b0, 1'b0, 0);
        check("mode_hold",    0, int'(hour),       15);

        // day_tick is a single-cycle pulse aligned with the wrap.
        step(1'b0, 1'b1, 23);
        step(1'b1, 1'b0, 0);
        check("wrap_hour", 0, int'(hour), 0);
        check("wrap_day",  0, int'(day_tick), 1);
        step(1'b1, 1'b0, 0);
        check("wrap_day_clear", 0, int'(day_tick), 0);
        check("wrap_hold",      0, int'(hour), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
